// File: rtl/pwm_cap_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_cap_pkg
//  Brief    : Shared FSM state type and default parameters for pwm_capture.
//  Revision : 1.0 - initial release
// ============================================================================
package pwm_cap_pkg;

   localparam int DEF_CNT_W       = 32;
   localparam int DEF_TIMEOUT_CYC = 50_000_000;
   localparam int DEF_FILT_LEN    = 4;

   typedef enum logic [1:0] {
      WAIT_RISE = 2'd0,
      HIGH      = 2'd1,
      LOW       = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/pwm_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_edge_sync
//  Brief    : Two-flop synchronizer, optional glitch filter and edge detector
//             for the asynchronous PWM input.
//             Macro PWM_CAPTURE_GLITCH_FILTER_EN compiles the filter in.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_edge_sync
   import pwm_cap_pkg::*;
#(
   parameter int FILT_LEN = DEF_FILT_LEN
) (
   input  logic clk,
   input  logic rst_n,
   input  logic pwm_in,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;
   logic s3;

   // Two-flop synchronizer for the asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= pwm_in;
         s2 <= s1;
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   generate
      if (FILT_LEN <= 1) begin : g_filt_bypass
         assign lvl = s2;
      end else begin : g_filt
         // The filtered level follows s2 once s2 has held its new value for
         // FILT_LEN-1 further edges, adding FILT_LEN-1 cycles of latency.
         localparam int FW  = $clog2(FILT_LEN + 1);
         localparam int THR = FILT_LEN - 2;

         logic          filt;
         logic [FW-1:0] scnt;

         // Stability counter: restarts whenever s2 agrees with the output.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               filt <= 1'b0;
               scnt <= '0;
            end else if (s2 == filt) begin
               scnt <= '0;
            end else if (int'(scnt) >= THR) begin
               filt <= s2;
               scnt <= '0;
            end else begin
               scnt <= scnt + 1'b1;
            end
         end

         assign lvl = filt;
      end
   endgenerate
`else
   assign lvl = s2;
`endif

   // One more register stage gives the previous level for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3 <= 1'b0;
      end else begin
         s3 <= lvl;
      end
   end

   assign rise = lvl & ~s3;
   assign fall = ~lvl & s3;

endmodule
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
//  Module   : pwm_capture
//  Brief    : Measures period and high time of an asynchronous PWM signal in
//             clk cycles and flags a stalled input with a timeout.
//             Macro PWM_CAPTURE_GLITCH_FILTER_EN enables the input filter.
//  Revision : 1.0 - initial release
// ============================================================================
module pwm_capture
   import pwm_cap_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
   parameter int FILT_LEN    = DEF_FILT_LEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             timeout,
   output logic             stuck_level
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT_CYC);

   logic lvl;
   logic rise;
   logic fall;

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nx;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] hi_lat;
   logic [CNT_W-1:0] hi_lat_nx;
   logic [CNT_W-1:0] period_nx;
   logic [CNT_W-1:0] high_time_nx;
   logic             valid_nx;
   logic             timeout_nx;
   logic             stuck_nx;

   pwm_edge_sync #(
      .FILT_LEN (FILT_LEN)
   ) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .pwm_in (pwm_in),
      .lvl    (lvl),
      .rise   (rise),
      .fall   (fall)
   );

   // Saturating increment: the counter sticks at all-ones instead of wrapping.
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

   // Next-state and output logic; a rise always wins over a same-cycle timeout.
   always_comb begin
      state_nx     = state;
      cnt_nx       = cnt;
      hi_lat_nx    = hi_lat;
      period_nx    = period;
      high_time_nx = high_time;
      valid_nx     = 1'b0;
      timeout_nx   = timeout;
      stuck_nx     = stuck_level;
      case (state)
         WAIT_RISE: begin
            if (rise) begin
               state_nx   = HIGH;
               cnt_nx     = CNT_ONE;
               timeout_nx = 1'b0;
            end else if (fall) begin
               timeout_nx = 1'b0;
               cnt_nx     = '0;
            end else if (!timeout) begin
               if (cnt >= TO_LIM) begin
                  timeout_nx = 1'b1;
                  stuck_nx   = lvl;
                  cnt_nx     = '0;
               end else begin
                  cnt_nx = cnt_inc;
               end
            end
         end
         HIGH: begin
            if (fall) begin
               state_nx  = LOW;
               hi_lat_nx = cnt;
               cnt_nx    = cnt_inc;
            end else if (cnt >= TO_LIM) begin
               state_nx   = WAIT_RISE;
               timeout_nx = 1'b1;
               stuck_nx   = lvl;
               cnt_nx     = '0;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         LOW: begin
            if (rise) begin
               state_nx     = HIGH;
               period_nx    = cnt;
               high_time_nx = hi_lat;
               valid_nx     = 1'b1;
               cnt_nx       = CNT_ONE;
            end else if (cnt >= TO_LIM) begin
               state_nx   = WAIT_RISE;
               timeout_nx = 1'b1;
               stuck_nx   = lvl;
               cnt_nx     = '0;
            end else begin
               cnt_nx = cnt_inc;
            end
         end
         default: begin
            state_nx = WAIT_RISE;
            cnt_nx   = '0;
         end
      endcase
   end

   // State, counters and output registers; reset discards any partial period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= WAIT_RISE;
         cnt         <= '0;
         hi_lat      <= '0;
         period      <= '0;
         high_time   <= '0;
         valid       <= 1'b0;
         timeout     <= 1'b0;
         stuck_level <= 1'b0;
      end else begin
         state       <= state_nx;
         cnt         <= cnt_nx;
         hi_lat      <= hi_lat_nx;
         period      <= period_nx;
         high_time   <= high_time_nx;
         valid       <= valid_nx;
         timeout     <= timeout_nx;
         stuck_level <= stuck_nx;
      end
   end

endmodule
`default_nettype wire

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 32: width of the period and high-time counters.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 50_000_000: number of cycles without an edge that is declared a stall (1 s at 50 MHz).
REQ-003 SHALL have parameter FILT_LEN, default 4: minimum stable width in cycles, used only when the filter is compiled in.
REQ-004 SHALL have port clk, input, 1 bit: single 50 MHz clock.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port pwm_in, input, 1 bit: asynchronous PWM to measure, for example the buzzer output.
REQ-007 SHALL have port period, output, CNT_W bits: last complete period in clk cycles, rising edge to rising edge.
REQ-008 SHALL have port high_time, output, CNT_W bits: high portion of that same period in clk cycles.
REQ-009 SHALL have port valid, output, 1 bit: one-cycle pulse when period and high_time update.
REQ-010 SHALL have port timeout, output, 1 bit: level, set while pwm_in is stalled.
REQ-011 SHALL have port stuck_level, output, 1 bit: synchronized pwm_in level captured when timeout asserts.

Function
REQ-012 SHALL synchronize pwm_in through two flops (s1, s2), then register once more (s3) for edge detection.
- rise = s2 & ~s3; fall = ~s2 & s3.
REQ-013 SHALL implement FSM states WAIT_RISE, HIGH, LOW.
- WAIT_RISE -> HIGH on rise; cnt = 1.
- HIGH -> LOW on fall; hi_lat = cnt; cnt increments.
- LOW -> HIGH on rise; period = cnt, high_time = hi_lat, valid = 1 for one cycle, cnt = 1.
REQ-014 SHALL assert valid exactly 3 clk cycles after the pwm_in rising edge that closes the period (2 sync cycles + 1 register cycle).
REQ-015 SHALL NOT assert valid for the first rising edge after reset or after timeout; two rising edges are required.
REQ-016 SHALL hold period and high_time stable between valid pulses.
REQ-017 SHALL increment cnt every cycle in HIGH and LOW and saturate it at 2^CNT_W-1, never wrapping.
REQ-018 SHALL handle timeout as follows when cnt reaches TIMEOUT_CYC in HIGH or LOW, or when no rise arrives in WAIT_RISE within TIMEOUT_CYC:
- assert timeout and set stuck_level = s2;
- go to WAIT_RISE;
- leave period and high_time unchanged.
REQ-019 SHALL clear timeout on the next rise or fall; a rise in the clearing cycle also enters HIGH.
REQ-020 SHALL treat a rise and a timeout in the same cycle as a rise: no timeout is asserted.
REQ-021 SHALL report a period of N cycles as period = N, and a duty of H cycles as high_time = H, exactly (±0 for a synchronous stimulus).

Reset
REQ-022 SHALL on rst_n low, asynchronously:
- state = WAIT_RISE; s1, s2, s3 = 0; cnt = 0; hi_lat = 0;
- period = 0, high_time = 0, valid = 0, timeout = 0, stuck_level = 0.
REQ-023 SHALL discard any partial measurement when reset asserts mid-period; the first valid after release needs two fresh rising edges.

Configuration
REQ-024 SHALL compile the glitch filter in with macro PWM_CAPTURE_GLITCH_FILTER_EN.
- Defined: s2 passes to edge detection only after staying stable for FILT_LEN consecutive cycles, so pulses shorter than FILT_LEN cycles are ignored and latency becomes 3+FILT_LEN-1 cycles.
- Undefined: no filter, latency per REQ-014, and FILT_LEN is unused.

Structure
REQ-025 SHALL place the FSM state typedef and the default constants (CNT_W, TIMEOUT_CYC, FILT_LEN) in shared package pwm_cap_pkg.
REQ-026 SHALL put the synchronizer, optional filter and edge detector in sub-module pwm_edge_sync (outputs lvl, rise, fall); the FSM, counters and outputs stay in pwm_capture.

Verification
REQ-027 SHALL cover: period 1000 cycles, high 250, driven for 5 periods -> 4 valid pulses, each with period=1000 and high_time=250; no valid on the first rise.
REQ-028 SHALL cover: duty changes from 250 to 900 at a period boundary -> the next valid reports high_time=900 and period=1000.
REQ-029 SHALL cover: pwm_in held high with TIMEOUT_CYC=5000 -> timeout=1 with stuck_level=1 at cnt=5000; the next fall clears timeout; the second subsequent rise produces valid.
REQ-030 SHALL cover: rst_n pulsed low for 3 cycles mid-HIGH -> all outputs are 0 immediately and no valid occurs until two rises after release.
REQ-031 SHALL cover, with PWM_CAPTURE_GLITCH_FILTER_EN defined and FILT_LEN=4: 2-cycle bounce pulses inside a 1000/500 PWM -> reported period=1000, high_time=500, and valid appears 6 cycles after the rise.
REQ-032 SHALL cover: period 3 cycles, high 1 (minimum, filter off) -> period=3, high_time=1 on every valid.
